// File: rtl/nibble_packer.sv
// nibble_packer
//   Collects a serial stream of 4-bit nibbles on a valid/ready input and
//   assembles them into one packed WIDTH x 4-bit word on a valid/ready
//   output. A frame that ends early (s_last before WIDTH nibbles) is padded
//   with PAD_VALUE, and m_count reports how many real nibbles it holds.
//   m_data feeds the downstream packed register directly, and both blocks
//   share the same RESET_VALUE.
//
// Ports
//   clk       clock, all logic on posedge
//   reset     synchronous, active-high reset
//   s_valid   input nibble valid
//   s_ready   block can accept a nibble (high in FILL)
//   s_nibble  input nibble
//   s_last    current nibble ends the frame
//   m_valid   m_data holds a complete word (high in HOLD)
//   m_ready   downstream accepts the word
//   m_data    assembled word; nibble k is the k-th accepted nibble
//   m_count   number of real nibbles in m_data (1..WIDTH)

module nibble_packer #(
    parameter int unsigned        WIDTH       = 4,
    parameter logic [WIDTH*4-1:0] RESET_VALUE = '1,
    parameter logic [3:0]         PAD_VALUE   = 4'h0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [3:0]                    s_nibble,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [WIDTH-1:0][3:0]         m_data,
    output logic [$clog2(WIDTH+1)-1:0]    m_count
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] idx;
    logic          accept;
    logic          last_fill;

    assign accept    = s_valid & s_ready;
    // The nibble being accepted closes the word either because the frame
    // ends here or because it lands in the final position.
    assign last_fill = s_last || (idx == CW'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && last_fill) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // NOTE: m_data is a register bank that is deliberately reset, because it
    // drives the downstream register and must show RESET_VALUE out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            m_count <= '0;
            m_data  <= RESET_VALUE;
        end else if (accept) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (CW'(k) == idx) begin
                    m_data[k] <= s_nibble;
                end else if (last_fill && (CW'(k) > idx)) begin
                    // Pad the unfilled tail in the same cycle the word closes.
                    m_data[k] <= PAD_VALUE;
                end
            end
            if (last_fill) begin
                idx     <= '0;
                m_count <= idx + CW'(1);
            end else begin
                idx     <= idx + CW'(1);
            end
        end
    end

endmodule
